// File: rtl/controlador_display_multiplexado.sv
// Purpose : time-multiplexed driver for four 7-segment digits sharing one BCD decoder.
// Latency : outputs are registered and reflect the scan state that starts on the same edge; loads appear at the next scan boundary.
// Backpres: none; carregar is always accepted and a newer load overwrites an untransferred one.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   digitos[15:0]     - four BCD digits, [3:0] rightmost (digit 0)
//   carregar          - load strobe into the pending buffer
//   habilita          - scan enable; low keeps the display dark and freezes the scan
//   supressao_zeros   - blank leading zeros (digit 0 is never blanked)
//   bcd_saida[3:0]    - code for the shared decoder, 4'hF = blank
//   anodos[3:0]       - active-low digit selects
//   indice[1:0]       - digit currently being scanned
//   fim_varredura     - one-cycle pulse in the first blank cycle of each new scan
module controlador_display_multiplexado #(
    parameter int DIVISOR    = 50000,
    parameter int APAGAMENTO = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] digitos,
    input  logic        carregar,
    input  logic        habilita,
    input  logic        supressao_zeros,
    output logic [3:0]  bcd_saida,
    output logic [3:0]  anodos,
    output logic [1:0]  indice,
    output logic        fim_varredura
);

    // The slot counter must hold the last count of the longer of the two slots.
    localparam int MAX_SLOT = (DIVISOR > APAGAMENTO) ? DIVISOR : APAGAMENTO;
    localparam int CW       = $clog2(MAX_SLOT);

    localparam logic [CW-1:0] ULTIMO_EXIBE = CW'(DIVISOR - 1);
    localparam logic [CW-1:0] ULTIMO_APAGA = CW'(APAGAMENTO - 1);

    typedef enum logic {
        APAGA = 1'b0,
        EXIBE = 1'b1
    } estado_t;

    estado_t       estado, estado_n;
    logic [CW-1:0] contador, contador_n;
    logic [1:0]    indice_n;
    logic          fim_n;

    logic [15:0]   pendente, pendente_n;
    logic          pendente_vld, pendente_vld_n;
    logic [15:0]   exibido, exibido_n;

    logic [3:0]    bcd_n;
    logic [3:0]    anodos_n;
    logic          transferir;

    // Digit presented to the decoder: blanked when it and every digit to its
    // left are zero and suppression is on. Codes A-F are passed untouched.
    function automatic logic [3:0] digito_visivel(input logic [15:0] valor,
                                                  input logic [1:0]  idx,
                                                  input logic        suprimir);
        logic [3:0] dig;
        logic       zeros_a_esquerda;
        dig              = 4'h0;
        zeros_a_esquerda = 1'b0;
        case (idx)
            2'd0: begin
                dig              = valor[3:0];
                zeros_a_esquerda = 1'b0;
            end
            2'd1: begin
                dig              = valor[7:4];
                zeros_a_esquerda = (valor[15:4] == 12'h000);
            end
            2'd2: begin
                dig              = valor[11:8];
                zeros_a_esquerda = (valor[15:8] == 8'h00);
            end
            default: begin
                dig              = valor[15:12];
                zeros_a_esquerda = (valor[15:12] == 4'h0);
            end
        endcase
        return (suprimir && zeros_a_esquerda) ? 4'hF : dig;
    endfunction

    // Scan sequencing.
    always_comb begin
        estado_n   = estado;
        contador_n = contador;
        indice_n   = indice;
        fim_n      = 1'b0;
        if (!habilita) begin
            // Park in a blank slot at the current digit so that re-enabling
            // restarts with a full anti-ghosting interval.
            estado_n   = APAGA;
            contador_n = '0;
        end else begin
            case (estado)
                APAGA: begin
                    if (contador == ULTIMO_APAGA) begin
                        estado_n   = EXIBE;
                        contador_n = '0;
                    end else begin
                        contador_n = contador + 1'b1;
                    end
                end
                default: begin
                    if (contador == ULTIMO_EXIBE) begin
                        estado_n   = APAGA;
                        contador_n = '0;
                        indice_n   = indice + 2'd1;
                        fim_n      = (indice == 2'd3);
                    end else begin
                        contador_n = contador + 1'b1;
                    end
                end
            endcase
        end
    end

    // Double buffering: the shown value only changes at a scan boundary (or
    // while dark), so a scan never mixes old and new digits.
    always_comb begin
        pendente_n     = pendente;
        pendente_vld_n = pendente_vld;
        exibido_n      = exibido;
        transferir     = fim_n || !habilita;
        if (transferir) begin
            if (carregar) begin
                exibido_n = digitos;
            end else if (pendente_vld) begin
                exibido_n = pendente;
            end
            pendente_vld_n = 1'b0;
        end else if (carregar) begin
            pendente_n     = digitos;
            pendente_vld_n = 1'b1;
        end
    end

    // Output values for the state entered on this edge. The decoder code is
    // driven in the blank slot too, so it has settled before the anode opens.
    always_comb begin
        bcd_n    = digito_visivel(exibido_n, indice_n, supressao_zeros);
        anodos_n = 4'b1111;
        if (estado_n == EXIBE) begin
            anodos_n = ~(4'b0001 << indice_n);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= APAGA;
            contador      <= '0;
            indice        <= 2'd0;
            pendente      <= 16'h0000;
            pendente_vld  <= 1'b0;
            exibido       <= 16'h0000;
            bcd_saida     <= 4'hF;
            anodos        <= 4'b1111;
            fim_varredura <= 1'b0;
        end else begin
            estado        <= estado_n;
            contador      <= contador_n;
            indice        <= indice_n;
            pendente      <= pendente_n;
            pendente_vld  <= pendente_vld_n;
            exibido       <= exibido_n;
            bcd_saida     <= bcd_n;
            anodos        <= anodos_n;
            fim_varredura <= fim_n;
        end
    end

endmodule

// File: tb/tb_controlador_display_multiplexado.sv
// Purpose : scoreboard bench for controlador_display_multiplexado (DIVISOR=4, APAGAMENTO=2).
// Latency : one expected entry per clock cycle, compared at the falling edge.
// Backpres: none; the monitor drains the expectation queue as cycles pass.
module tb_controlador_display_multiplexado;

    localparam int DIV = 4;
    localparam int APG = 2;
    localparam int SLOT = DIV + APG;

    logic        clk;
    logic        reset;
    logic [15:0] digitos;
    logic        carregar;
    logic        habilita;
    logic        supressao_zeros;
    logic [3:0]  bcd_saida;
    logic [3:0]  anodos;
    logic [1:0]  indice;
    logic        fim_varredura;

    controlador_display_multiplexado #(
        .DIVISOR   (DIV),
        .APAGAMENTO(APG)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .digitos        (digitos),
        .carregar       (carregar),
        .habilita       (habilita),
        .supressao_zeros(supressao_zeros),
        .bcd_saida      (bcd_saida),
        .anodos         (anodos),
        .indice         (indice),
        .fim_varredura  (fim_varredura)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] an;
        logic [3:0] bcd;
        bit         chk_bcd;
        logic [1:0] idx;
        logic       fim;
        int         ciclo;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   ciclo    = 0;

    task automatic compara(input string nome, input int cyc,
                           input logic [3:0] real_v, input logic [3:0] esperado);
        n_checks++;
        if (real_v !== esperado) begin
            $display("FAIL %s cycle %0d: got %h expected %h", nome, cyc, real_v, esperado);
        end else begin
            n_pass++;
        end
    endtask

    // Monitor: one expectation per cycle, compared away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            compara("anodos", e.ciclo, anodos, e.an);
            compara("indice", e.ciclo, {2'b00, indice}, {2'b00, e.idx});
            compara("fim_varredura", e.ciclo, {3'b000, fim_varredura}, {3'b000, e.fim});
            if (e.chk_bcd) begin
                compara("bcd_saida", e.ciclo, bcd_saida, e.bcd);
            end
        end
    end

    // Advance one cycle and queue what the outputs must show during it.
    task automatic step(input logic [3:0] an, input logic [3:0] bcd, input bit chk,
                        input logic [1:0] idx, input logic fim);
        exp_t e;
        @(posedge clk);
        #1;
        ciclo++;
        e.an      = an;
        e.bcd     = bcd;
        e.chk_bcd = chk;
        e.idx     = idx;
        e.fim     = fim;
        e.ciclo   = ciclo;
        exp_q.push_back(e);
    endtask

    // Positions [ini, fim) of one digit slot: APG blank cycles, then DIV lit
    // cycles. Any carregar pulse issued just before is dropped after one edge.
    task automatic slot(input logic [1:0] idx, input logic [3:0] dig, input bit pulso,
                        input int ini, input int fim);
        for (int k = ini; k < fim; k++) begin
            logic [3:0] an;
            an = (k < APG) ? 4'b1111 : ~(4'b0001 << idx);
            step(an, dig, 1'b1, idx, pulso && (k == 0));
            carregar = 1'b0;
        end
    endtask

    task automatic varredura(input logic [15:0] mostrado, input bit pulso);
        slot(2'd0, mostrado[3:0],   pulso, 0, SLOT);
        slot(2'd1, mostrado[7:4],   1'b0,  0, SLOT);
        slot(2'd2, mostrado[11:8],  1'b0,  0, SLOT);
        slot(2'd3, mostrado[15:12], 1'b0,  0, SLOT);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        habilita        = 1'b0;
        carregar        = 1'b0;
        supressao_zeros = 1'b0;
        digitos         = 16'h0000;

        // Reset values.
        step(4'b1111, 4'hF, 1'b1, 2'd0, 1'b0);
        step(4'b1111, 4'hF, 1'b1, 2'd0, 1'b0);

        // Release and enable: this cycle is the first blank cycle of digit 0.
        reset    = 1'b0;
        habilita = 1'b1;
        slot(2'd0, 4'h0, 1'b0, 1, SLOT);
        slot(2'd1, 4'h0, 1'b0, 0, SLOT);
        // Mid-scan load goes to pending; current scan keeps showing zeros.
        carregar = 1'b1;
        digitos  = 16'h1234;
        slot(2'd2, 4'h0, 1'b0, 0, SLOT);
        slot(2'd3, 4'h0, 1'b0, 0, SLOT);

        // Pending value appears at the boundary.
        slot(2'd0, 4'h4, 1'b1, 0, SLOT);
        slot(2'd1, 4'h3, 1'b0, 0, SLOT);
        slot(2'd2, 4'h2, 1'b0, 0, SLOT);
        slot(2'd3, 4'h1, 1'b0, 0, SLOT);

        // Load on the boundary edge itself is shown in the scan now starting.
        carregar = 1'b1;
        digitos  = 16'h9876;
        varredura(16'h9876, 1'b1);

        // Leading-zero suppression on 0045.
        carregar        = 1'b1;
        digitos         = 16'h0045;
        supressao_zeros = 1'b1;
        slot(2'd0, 4'h5, 1'b1, 0, SLOT);
        slot(2'd1, 4'h4, 1'b0, 0, SLOT);
        carregar = 1'b1;
        digitos  = 16'h0000;
        slot(2'd2, 4'hF, 1'b0, 0, SLOT);
        slot(2'd3, 4'hF, 1'b0, 0, SLOT);

        // All-zero display: only digit 0 is lit with 0.
        slot(2'd0, 4'h0, 1'b1, 0, SLOT);
        slot(2'd1, 4'hF, 1'b0, 0, SLOT);
        slot(2'd2, 4'hF, 1'b0, 0, SLOT);
        slot(2'd3, 4'hF, 1'b0, 0, SLOT);

        // Non-BCD codes pass through; inner zero stays visible.
        carregar = 1'b1;
        digitos  = 16'hA0B0;
        varredura(16'hA0B0, 1'b1);

        // Disable during the second lit cycle of digit 2.
        slot(2'd0, 4'h0, 1'b1, 0, SLOT);
        slot(2'd1, 4'hB, 1'b0, 0, SLOT);
        slot(2'd2, 4'h0, 1'b0, 0, APG + 2);
        habilita = 1'b0;
        step(4'b1111, 4'h0, 1'b1, 2'd2, 1'b0);
        // While dark a load goes straight to the display.
        carregar = 1'b1;
        digitos  = 16'h0300;
        step(4'b1111, 4'h3, 1'b1, 2'd2, 1'b0);
        carregar = 1'b0;
        step(4'b1111, 4'h3, 1'b1, 2'd2, 1'b0);
        // Re-enable: this cycle is blank position 0 of digit 2.
        habilita = 1'b1;
        slot(2'd2, 4'h3, 1'b0, 1, SLOT);
        slot(2'd3, 4'hF, 1'b0, 0, SLOT);

        // Reset during lit phase of digit 3 with a pending load outstanding.
        slot(2'd0, 4'h0, 1'b1, 0, SLOT);
        slot(2'd1, 4'h0, 1'b0, 0, SLOT);
        carregar = 1'b1;
        digitos  = 16'h7777;
        slot(2'd2, 4'h3, 1'b0, 0, SLOT);
        slot(2'd3, 4'hF, 1'b0, 0, APG + 1);
        reset = 1'b1;
        step(4'b1111, 4'hF, 1'b1, 2'd0, 1'b0);
        reset           = 1'b0;
        supressao_zeros = 1'b0;
        slot(2'd0, 4'h0, 1'b0, 1, SLOT);
        slot(2'd1, 4'h0, 1'b0, 0, SLOT);
        slot(2'd2, 4'h0, 1'b0, 0, SLOT);
        slot(2'd3, 4'h0, 1'b0, 0, SLOT);
        // Pending 7777 was discarded: the next scan still shows zeros.
        varredura(16'h0000, 1'b1);

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/controlador_display_multiplexado.md
CONTROLADOR_DISPLAY_MULTIPLEXADO -- requirements
Module: controlador_display_multiplexado

Interface
REQ-001 Parameter DIVISOR, default 50000: clock cycles each digit is lit (EXIBE slot); SHALL be >= 2.
REQ-002 Parameter APAGAMENTO, default 4: anti-ghosting blank cycles before each digit; SHALL be >= 1.
REQ-003 clk  input  1  single system clock; all state changes SHALL occur on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 digitos  input  16  four BCD digits; [3:0]=digit 0 (rightmost), [15:12]=digit 3.
REQ-006 carregar  input  1  load strobe; samples digitos into the pending buffer.
REQ-007 habilita  input  1  scan enable; low = display dark, scan frozen.
REQ-008 supressao_zeros  input  1  leading-zero blanking enable.
REQ-009 bcd_saida  output  4  code for the shared BCD-to-7-segment decoder; 4'hF = blank (decoder lights no segment).
REQ-010 anodos  output  4  active-low digit selects; at most one bit low.
REQ-011 indice  output  2  index of the digit being scanned.
REQ-012 fim_varredura  output  1  one-cycle pulse at end of each full 4-digit scan.

Function
REQ-013 All outputs SHALL be registered.
REQ-014 Storage: pending register plus pending flag; display register; decoder input SHALL come only from the display register.
REQ-015 carregar high SHALL write digitos to pending and set the flag on the next edge; a later carregar before transfer overwrites pending.
REQ-016 Transfer (pending -> display, flag cleared) SHALL occur on the scan-boundary edge (fim_varredura rising) or on any edge with habilita low; carregar in the same cycle writes digitos straight to display and leaves the flag clear.
REQ-017 FSM states: APAGA, EXIBE; slot counter runs 0..N-1, transitions on count N-1.
REQ-018 APAGA: anodos=4'b1111, bcd_saida = digit[indice] (decoder pre-settles); exactly APAGAMENTO cycles, then EXIBE.
REQ-019 EXIBE: anodos bit[indice]=0, others 1, bcd_saida unchanged; exactly DIVISOR cycles, then APAGA with indice incremented modulo 4 (3 -> 0).
REQ-020 fim_varredura SHALL be high exactly the first APAGA cycle after digit 3's EXIBE; scan period = 4*(DIVISOR+APAGAMENTO) cycles.
REQ-021 Leading-zero suppression: with supressao_zeros=1, digit i (i=1..3) SHALL output 4'hF when digits i..3 are all zero; digit 0 is never suppressed.
REQ-022 Non-BCD digits (A-F) SHALL pass through unmodified.
REQ-023 habilita low: next edge forces APAGA, counter=0, anodos=4'b1111, fim_varredura=0, indice held; on reassert the scan resumes with a full APAGA slot at the held indice.
REQ-024 Width rule: counter wide enough for max(DIVISOR, APAGAMENTO)-1, no overflow.

Reset
REQ-025 reset high at an edge SHALL set: state APAGA, counter 0, indice 0, display and pending registers 0, flag 0, anodos 4'b1111, bcd_saida 4'hF, fim_varredura 0.
REQ-026 reset SHALL take precedence over carregar and habilita; mid-scan reset discards pending and display data.
REQ-027 First cycle after reset release SHALL start an APAGA slot of digit 0.

Verification (DIVISOR=4, APAGAMENTO=2)
REQ-028 Reset then habilita=1 -> anodos 1111 for 2 cycles, 1110 for 4, 1111 for 2, 1101 for 4...; fim_varredura every 24 cycles.
REQ-029 carregar with 16'h1234 mid-scan -> current scan shows 0000; after fim_varredura, digit 0=4, 1=3, 2=2, 3=1 on bcd_saida.
REQ-030 supressao_zeros=1, display 16'h0045 -> digits 3,2 = F, 1=4, 0=5; display 16'h0000 -> digits 3..1 = F, digit 0 = 0.
REQ-031 carregar 16'h9876 in the fim_varredura boundary cycle -> shown in the scan just starting; pending flag clear.
REQ-032 habilita low during EXIBE of digit 2 -> next cycle anodos 1111, indice=2 held; reassert -> 2 APAGA then 4 EXIBE cycles with anodos 1011.
REQ-033 reset asserted during EXIBE of digit 3 with pending set -> all REQ-025 values; display 0000 afterwards, no fim_varredura pulse.
